dac12_sample_feeder: RTL
========================

# dac12_sample_feeder

Upstream feeder for the 12-bit DAC core in `tt_um_dac12`. It assembles 12-bit samples from byte writes on the 8-bit dedicated input bus and buffers them in a small FIFO. It then releases samples to the DAC at a fixed, programmable sample rate, so host write jitter never reaches the DAC input. It also reports underrun and overflow so firmware can tune the write pacing.

## Interface
Parameters:
- `DEPTH`, 4: FIFO depth in samples; a power of two, at least 2.
- `DIV_W`, 16: width of the sample-period divider.

Ports:
- `clk`  in  1  single system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_byte_i`  in  8  write data byte.
- `wr_stb_i`  in  1  one-cycle strobe; qualifies `wr_byte_i`.
- `sync_i`  in  1  forces byte phase back to LOW.
- `en_i`  in  1  playout enable.
- `div_i`  in  DIV_W  sample period minus 1, in clocks.
- `clr_flags_i`  in  1  clears the sticky flags.
- `sample_o`  out  12  current DAC code; registered.
- `sample_vld_o`  out  1  one-cycle pulse when `sample_o` takes a new value.
- `level_o`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `underrun_o`  out  1  sticky; a tick found the FIFO empty.
- `overflow_o`  out  1  sticky; a completed sample was dropped because the FIFO was full.

## Operation
Byte assembler:
- Phase register holds LOW or HIGH.
- Strobe in LOW phase: latch `wr_byte_i` as bits [7:0], go to HIGH.
- Strobe in HIGH phase: form `{wr_byte_i[3:0], low_byte}`, push it, go to LOW. `wr_byte_i[7:4]` is ignored.
- `sync_i` forces LOW and discards any latched low byte. If `sync_i` and `wr_stb_i` are high in the same cycle, `sync_i` wins and the byte is dropped.

FIFO:
- Circular buffer of `DEPTH` entries with read/write pointers and a count of width `$clog2(DEPTH)+1`.
- Pointers wrap modulo `DEPTH`.
- A push when full (`level_o==DEPTH`) with no simultaneous pop: the sample is dropped, `overflow_o` sets, and the FIFO is unchanged.
- Push and pop in the same cycle when full: both succeed and level stays `DEPTH`.
- Push and pop in the same cycle when empty: the pop fails (underrun), the push lands, and level becomes 1. There is no bypass.

Playout divider:
- `cnt` counts 0..`div_i`; tick is asserted when `cnt==div_i` and `en_i`=1. On the tick, `cnt` returns to 0.
- `en_i`=0: `cnt` is held at 0, there are no ticks, and the FIFO keeps filling.
- If `div_i` changes below the current `cnt`, `cnt` keeps counting and wraps at 2^DIV_W. Firmware changes `div_i` only with `en_i`=0.
- `div_i`=0 gives a tick every enabled cycle.
- Tick with FIFO non-empty: pop the head into `sample_o` and pulse `sample_vld_o`.
- Tick with FIFO empty: `sample_o` holds its last value, there is no pulse, and `underrun_o` sets.

Flags:
- `underrun_o` and `overflow_o` clear on `clr_flags_i`.
- If a set event and `clr_flags_i` coincide, the set wins.

## Timing
- Reset values (asynchronous, at `rst`=1): `sample_o`=12'h800 (mid-scale), `sample_vld_o`=0, `level_o`=0, `underrun_o`=0, `overflow_o`=0, phase=LOW, `cnt`=0, pointers=0.
- HIGH-byte strobe at edge n: `level_o` increments after edge n (visible in cycle n+1).
- Tick at edge t: `sample_o` shows the new value and `sample_vld_o`=1 for exactly cycle t+1; `level_o` decrements in the same cycle.
- Write-to-output latency with an empty FIFO and an enabled divider: the sample appears on the first tick strictly after its push edge.
- With `en_i` held high, tick spacing is exactly `div_i`+1 clocks.
- Asserting `rst` mid-operation flushes the FIFO, loses any half-assembled sample, and returns every output to its reset value immediately, without waiting for a clock edge.

## Test plan
- Reset: assert `rst` between edges -> `sample_o`=0x800, `level_o`=0, and both flags 0 with no clock edge.
- Assembly plus ignored nibble: bytes 0x34 then 0xF2, `div_i`=3, `en_i`=1 -> `sample_o`=0x234 one cycle after the next tick with a single `sample_vld_o` pulse; the next pulses are exactly 4 clocks apart when more data follows.
- Overflow: `DEPTH`=4, `en_i`=0, write 5 samples 0x001..0x005 -> `level_o`=4 and `overflow_o`=1. Then enable -> outputs 0x001..0x004 in order, and 0x005 is never seen.
- Underrun: after draining, the next tick -> `sample_o` holds 0x004, no pulse, `underrun_o`=1. Pulse `clr_flags_i` -> `underrun_o`=0.
- Simultaneous edges:
  - Full FIFO, push and tick in the same cycle -> `level_o` stays 4, no overflow.
  - Empty FIFO, push and tick in the same cycle -> underrun set, `level_o`=1.
- Resync: send a single byte 0xAA, pulse `sync_i`, then bytes 0x11, 0x03 -> sample 0x311 (not 0x1AA).

Source files
------------

// File: rtl/dac12_sample_feeder.sv
// rtl/dac12_sample_feeder.sv - byte-assembled 12-bit sample FIFO with fixed-rate DAC playout
module dac12_sample_feeder #(
    parameter int DEPTH = 4,
    parameter int DIV_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               wr_byte_i,
    input  logic                     wr_stb_i,
    input  logic                     sync_i,
    input  logic                     en_i,
    input  logic [DIV_W-1:0]         div_i,
    input  logic                     clr_flags_i,
    output logic [11:0]              sample_o,
    output logic                     sample_vld_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     underrun_o,
    output logic                     overflow_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    typedef enum logic {PH_LOW, PH_HIGH} phase_t;

    phase_t            r_phase;
    phase_t            w_phase_nxt;
    logic              w_latch_low;
    logic              w_push;
    logic [7:0]        r_low_byte;
    logic [11:0]       r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic [DIV_W-1:0]  r_cnt;
    logic [11:0]       r_sample;
    logic              r_vld;
    logic              r_underrun;
    logic              r_overflow;
    logic              w_empty;
    logic              w_full;
    logic              w_tick;
    logic              w_pop;
    logic              w_push_ok;
    logic              w_set_underrun;
    logic              w_set_overflow;
    logic              w_unused_high_nibble;

    // The upper nibble of the high byte carries no sample bits.
    assign w_unused_high_nibble = ^wr_byte_i[7:4];

    // Byte phase state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_phase <= PH_LOW;
        else     r_phase <= w_phase_nxt;
    end

    // Byte phase next state: sync always returns to LOW, each strobe toggles.
    always_comb begin
        w_phase_nxt = r_phase;
        if (sync_i)        w_phase_nxt = PH_LOW;
        else if (wr_stb_i) w_phase_nxt = (r_phase == PH_LOW) ? PH_HIGH : PH_LOW;
    end

    // Byte phase outputs: latch the low byte, or complete and push a sample.
    always_comb begin
        w_latch_low = wr_stb_i && !sync_i && (r_phase == PH_LOW);
        w_push      = wr_stb_i && !sync_i && (r_phase == PH_HIGH);
    end

    // Low byte holding register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              r_low_byte <= 8'h00;
        else if (w_latch_low) r_low_byte <= wr_byte_i;
    end

    assign w_empty        = (r_level == '0);
    assign w_full         = (r_level == FULL_LEVEL);
    assign w_tick         = en_i && (r_cnt == div_i);
    assign w_pop          = w_tick && !w_empty;
    // A full FIFO still accepts a push when the same cycle pops a slot free.
    assign w_push_ok      = w_push && (!w_full || w_pop);
    assign w_set_underrun = w_tick && w_empty;
    assign w_set_overflow = w_push && w_full && !w_pop;

    // Sample storage; contents are don't-care until written, reset flushes via pointers.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= {wr_byte_i[3:0], r_low_byte};
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Sample period counter; held at zero while playout is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_cnt <= '0;
        else if (!en_i)  r_cnt <= '0;
        else if (w_tick) r_cnt <= '0;
        else             r_cnt <= r_cnt + DIV_W'(1);
    end

    // DAC output register and its update pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample <= 12'h800;
            r_vld    <= 1'b0;
        end else begin
            r_vld <= w_pop;
            if (w_pop) r_sample <= r_mem[r_rd_ptr];
        end
    end

    // Sticky status flags; a set event outranks a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_underrun <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_set_underrun)   r_underrun <= 1'b1;
            else if (clr_flags_i) r_underrun <= 1'b0;
            if (w_set_overflow)   r_overflow <= 1'b1;
            else if (clr_flags_i) r_overflow <= 1'b0;
        end
    end

    assign sample_o     = r_sample;
    assign sample_vld_o = r_vld;
    assign level_o      = r_level;
    assign underrun_o   = r_underrun;
    assign overflow_o   = r_overflow;

endmodule
